// File: rtl/exception_ctrl.sv
// Exception/interrupt sequencer: latches UND/SWI/ERET events, takes them at
// instruction boundaries, saves PC/status, vectors the PC and restores on ERET.
module exception_ctrl #(
  parameter int unsigned NUM_IRQ = 4,
  parameter logic [31:0] VEC_UND = 32'h0000_0004,
  parameter logic [31:0] VEC_SWI = 32'h0000_0008,
  parameter logic [31:0] VEC_IRQ = 32'h0000_0018
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_IRQ-1:0] irq_req,
  input  logic [NUM_IRQ-1:0] irq_mask,
  input  logic               und_req,
  input  logic               swi_req,
  input  logic               eret_req,
  input  logic               instr_boundary,
  input  logic [31:0]        pc_cur,
  input  logic [31:0]        status_in,
  output logic               stall,
  output logic               pc_load,
  output logic [31:0]        pc_next,
  output logic               mode,
  output logic [3:0]         clr_flag,
  output logic               flag_restore_en,
  output logic [3:0]         flag_restore_val,
  output logic [31:0]        epc,
  output logic [31:0]        saved_status,
  output logic [1:0]         cause,
  output logic [NUM_IRQ-1:0] irq_ack,
  output logic               fatal
);

  localparam int unsigned SW = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1;

  typedef enum logic [1:0] {IDLE, SAVE, VECTOR, RESTORE} state_e;

  state_e             state_q, state_d;
  logic               pend_und_q, pend_und_d;
  logic               pend_swi_q, pend_swi_d;
  logic               pend_eret_q, pend_eret_d;
  logic               mode_q, mode_d;
  logic               fatal_q, fatal_d;
  logic [31:0]        epc_q, epc_d;
  logic [31:0]        saved_status_q, saved_status_d;
  logic [1:0]         cause_q, cause_d;
  logic [1:0]         next_cause_q, next_cause_d;
  logic [SW-1:0]      irq_sel_q, irq_sel_d;
  logic               pc_load_q, pc_load_d;
  logic [31:0]        pc_next_q, pc_next_d;
  logic [3:0]         clr_flag_q, clr_flag_d;
  logic               flag_restore_en_q, flag_restore_en_d;
  logic [3:0]         flag_restore_val_q, flag_restore_val_d;
  logic [NUM_IRQ-1:0] irq_ack_q, irq_ack_d;

  logic               take;
  logic               und_eff, swi_eff, eret_eff;
  logic [NUM_IRQ-1:0] irq_act;
  logic [SW-1:0]      irq_low;
  logic               irq_found;

  always_comb begin
    state_d            = state_q;
    mode_d             = mode_q;
    fatal_d            = fatal_q;
    epc_d              = epc_q;
    saved_status_d     = saved_status_q;
    cause_d            = cause_q;
    next_cause_d       = next_cause_q;
    irq_sel_d          = irq_sel_q;
    pc_next_d          = pc_next_q;
    pc_load_d          = 1'b0;
    clr_flag_d         = '0;
    flag_restore_en_d  = 1'b0;
    flag_restore_val_d = '0;
    irq_ack_d          = '0;
    take               = 1'b0;

    // A request pulse in the boundary cycle itself counts as pending.
    und_eff     = pend_und_q | und_req;
    swi_eff     = pend_swi_q | swi_req;
    eret_eff    = pend_eret_q | eret_req;
    pend_und_d  = und_eff;
    pend_swi_d  = swi_eff;
    pend_eret_d = eret_eff;

    irq_act   = irq_req & ~irq_mask;
    irq_low   = '0;
    irq_found = 1'b0;
    for (int unsigned i = 0; i < NUM_IRQ; i++) begin
      if (irq_act[i] && !irq_found) begin
        irq_low   = SW'(i);
        irq_found = 1'b1;
      end
    end

    unique case (state_q)
      IDLE: begin
        if (instr_boundary) begin
          if (eret_eff && mode_q) begin
            pend_eret_d = 1'b0;
            state_d     = RESTORE;
            take        = 1'b1;
          end else if (und_eff || eret_eff) begin
            // ERET from user mode is treated as an undefined instruction.
            pend_und_d  = 1'b0;
            pend_eret_d = 1'b0;
            if (mode_q) begin
              fatal_d = 1'b1;
            end else begin
              next_cause_d = 2'd1;
              state_d      = SAVE;
              take         = 1'b1;
            end
          end else if (swi_eff) begin
            pend_swi_d = 1'b0;
            if (!mode_q) begin
              next_cause_d = 2'd2;
              state_d      = SAVE;
              take         = 1'b1;
            end
          end else if (!mode_q && irq_found) begin
            next_cause_d = 2'd3;
            irq_sel_d    = irq_low;
            state_d      = SAVE;
            take         = 1'b1;
          end
        end
      end
      SAVE: begin
        epc_d          = pc_cur;
        saved_status_d = status_in;
        cause_d        = next_cause_q;
        state_d        = VECTOR;
      end
      VECTOR: begin
        mode_d  = 1'b1;
        state_d = IDLE;
      end
      RESTORE: begin
        mode_d  = saved_status_q[0];
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Strobes are registered from the upcoming state so they line up with it.
    if (state_d == VECTOR) begin
      pc_load_d  = 1'b1;
      clr_flag_d = 4'hF;
      unique case (next_cause_q)
        2'd1:    pc_next_d = VEC_UND;
        2'd2:    pc_next_d = VEC_SWI;
        2'd3:    pc_next_d = VEC_IRQ;
        default: pc_next_d = '0;
      endcase
      if (next_cause_q == 2'd3) begin
        for (int unsigned i = 0; i < NUM_IRQ; i++) begin
          irq_ack_d[i] = (irq_sel_q == SW'(i));
        end
      end
    end
    if (state_d == RESTORE) begin
      pc_load_d          = 1'b1;
      flag_restore_en_d  = 1'b1;
      flag_restore_val_d = saved_status_q[31:28];
      pc_next_d          = epc_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q            <= IDLE;
      pend_und_q         <= 1'b0;
      pend_swi_q         <= 1'b0;
      pend_eret_q        <= 1'b0;
      mode_q             <= 1'b1;
      fatal_q            <= 1'b0;
      epc_q              <= '0;
      saved_status_q     <= '0;
      cause_q            <= '0;
      next_cause_q       <= '0;
      irq_sel_q          <= '0;
      pc_load_q          <= 1'b0;
      pc_next_q          <= '0;
      clr_flag_q         <= '0;
      flag_restore_en_q  <= 1'b0;
      flag_restore_val_q <= '0;
      irq_ack_q          <= '0;
    end else begin
      state_q            <= state_d;
      pend_und_q         <= pend_und_d;
      pend_swi_q         <= pend_swi_d;
      pend_eret_q        <= pend_eret_d;
      mode_q             <= mode_d;
      fatal_q            <= fatal_d;
      epc_q              <= epc_d;
      saved_status_q     <= saved_status_d;
      cause_q            <= cause_d;
      next_cause_q       <= next_cause_d;
      irq_sel_q          <= irq_sel_d;
      pc_load_q          <= pc_load_d;
      pc_next_q          <= pc_next_d;
      clr_flag_q         <= clr_flag_d;
      flag_restore_en_q  <= flag_restore_en_d;
      flag_restore_val_q <= flag_restore_val_d;
      irq_ack_q          <= irq_ack_d;
    end
  end

  assign stall            = (state_q != IDLE) | take;
  assign pc_load          = pc_load_q;
  assign pc_next          = pc_next_q;
  assign mode             = mode_q;
  assign clr_flag         = clr_flag_q;
  assign flag_restore_en  = flag_restore_en_q;
  assign flag_restore_val = flag_restore_val_q;
  assign epc              = epc_q;
  assign saved_status     = saved_status_q;
  assign cause            = cause_q;
  assign irq_ack          = irq_ack_q;
  assign fatal            = fatal_q;

endmodule

// File: tb/tb_exception_ctrl.sv
// Scoreboard bench for exception_ctrl: a behavioural model predicts each
// boundary outcome; a monitor checks boundary cycles and every pc_load.
module tb_exception_ctrl;
  localparam int N = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [N-1:0]  irq_req = '0, irq_mask = '0;
  logic          und_req = 1'b0, swi_req = 1'b0, eret_req = 1'b0;
  logic          instr_boundary = 1'b0;
  logic [31:0]   pc_cur = '0, status_in = '0;
  logic          stall, pc_load, mode, flag_restore_en, fatal;
  logic [31:0]   pc_next, epc, saved_status;
  logic [3:0]    clr_flag, flag_restore_val;
  logic [1:0]    cause;
  logic [N-1:0]  irq_ack;

  always #5 clk = ~clk;

  exception_ctrl #(
    .NUM_IRQ(N),
    .VEC_UND(32'h0000_0004),
    .VEC_SWI(32'h0000_0008),
    .VEC_IRQ(32'h0000_0018)
  ) dut (
    .clk(clk), .rst_n(rst_n), .irq_req(irq_req), .irq_mask(irq_mask),
    .und_req(und_req), .swi_req(swi_req), .eret_req(eret_req),
    .instr_boundary(instr_boundary), .pc_cur(pc_cur), .status_in(status_in),
    .stall(stall), .pc_load(pc_load), .pc_next(pc_next), .mode(mode),
    .clr_flag(clr_flag), .flag_restore_en(flag_restore_en),
    .flag_restore_val(flag_restore_val), .epc(epc), .saved_status(saved_status),
    .cause(cause), .irq_ack(irq_ack), .fatal(fatal)
  );

  typedef struct {
    bit           is_eret;
    logic [31:0]  pc;
    bit           mode_after;
    logic [1:0]   cause;
    logic [31:0]  epc;
    logic [31:0]  ss;
    logic [N-1:0] ack;
    logic [3:0]   fval;
    int           stall_len;
  } exp_t;

  typedef struct {
    bit stall;
    bit fatal;
  } bexp_t;

  exp_t  q[$];
  bexp_t bq[$];
  int    n_chk = 0;
  int    n_fail = 0;

  // Reference model state
  bit          m_mode = 1'b1, m_fatal = 1'b0;
  bit          pu = 1'b0, ps = 1'b0, pe = 1'b0;
  logic [31:0] m_epc = '0, m_ss = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] vec_of(input int c);
    case (c)
      1: return 32'h4;
      2: return 32'h8;
      3: return 32'h18;
      default: return 32'h0;
    endcase
  endfunction

  task automatic model_reset();
    m_mode = 1'b1; m_fatal = 1'b0; pu = 0; ps = 0; pe = 0;
    m_epc = '0; m_ss = '0;
    q.delete(); bq.delete();
  endtask

  task automatic model_entry(input int c, input logic [N-1:0] ack,
                             input logic [31:0] pc, input logic [31:0] st);
    exp_t e;
    e.is_eret = 0; e.cause = 2'(c); e.pc = vec_of(c); e.ack = ack;
    e.epc = pc; e.ss = st; e.mode_after = 1'b1; e.fval = '0; e.stall_len = 3;
    m_epc = pc; m_ss = st; m_mode = 1'b1;
    q.push_back(e);
  endtask

  task automatic model_boundary(input logic [N-1:0] irq, input logic [N-1:0] msk,
                                input logic [31:0] pc, input logic [31:0] st);
    bexp_t b;
    exp_t  e;
    logic [N-1:0] act;
    b.fatal = m_fatal;
    b.stall = 1'b0;
    act = irq & ~msk;
    if (pe && m_mode) begin
      pe = 0;
      e.is_eret = 1; e.pc = m_epc; e.fval = m_ss[31:28]; e.mode_after = m_ss[0];
      e.cause = '0; e.epc = m_epc; e.ss = m_ss; e.ack = '0; e.stall_len = 2;
      m_mode = m_ss[0];
      q.push_back(e);
      b.stall = 1'b1;
    end else if (pu || pe) begin
      pu = 0; pe = 0;
      if (m_mode) m_fatal = 1'b1;
      else begin model_entry(1, '0, pc, st); b.stall = 1'b1; end
    end else if (ps) begin
      ps = 0;
      if (!m_mode) begin model_entry(2, '0, pc, st); b.stall = 1'b1; end
    end else if (!m_mode && act != 0) begin
      model_entry(3, act & (~act + 1'b1), pc, st);
      b.stall = 1'b1;
    end
    bq.push_back(b);
  endtask

  task automatic step(input bit u, input bit s, input bit e,
                      input logic [N-1:0] irq, input logic [N-1:0] msk,
                      input logic [31:0] pc, input logic [31:0] st);
    @(posedge clk); #1;
    und_req = u; swi_req = s; eret_req = e;
    irq_req = irq; irq_mask = msk; pc_cur = pc; status_in = st;
    pu |= u; ps |= s; pe |= e;
    @(posedge clk); #1;
    und_req = 0; swi_req = 0; eret_req = 0;
    instr_boundary = 1'b1;
    model_boundary(irq, msk, pc, st);
    @(posedge clk); #1;
    instr_boundary = 1'b0;
    repeat (4) @(posedge clk);
  endtask

  // Monitor
  initial begin
    int   run = 0;
    bit   mchk = 0;
    bit   mexp = 0;
    exp_t e;
    bexp_t b;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        run = 0; mchk = 0;
      end else begin
        if (mchk) begin
          chk("mode_after", 32'(mode), 32'(mexp));
          mchk = 0;
        end
        run = stall ? run + 1 : 0;
        if (instr_boundary && bq.size() > 0) begin
          b = bq.pop_front();
          chk("boundary_stall", 32'(stall), 32'(b.stall));
          chk("boundary_fatal", 32'(fatal), 32'(b.fatal));
        end
        if (pc_load) begin
          if (q.size() == 0) begin
            chk("unexpected_pc_load", 32'(pc_load), 32'd0);
          end else begin
            e = q.pop_front();
            chk("pc_next", pc_next, e.pc);
            chk("stall_len", 32'(run), 32'(e.stall_len));
            if (e.is_eret) begin
              chk("flag_restore_en", 32'(flag_restore_en), 32'd1);
              chk("flag_restore_val", 32'(flag_restore_val), 32'(e.fval));
              chk("clr_flag_eret", 32'(clr_flag), 32'd0);
              chk("irq_ack_eret", 32'(irq_ack), 32'd0);
            end else begin
              chk("cause", 32'(cause), 32'(e.cause));
              chk("epc", epc, e.epc);
              chk("saved_status", saved_status, e.ss);
              chk("clr_flag", 32'(clr_flag), 32'hF);
              chk("irq_ack", 32'(irq_ack), 32'(e.ack));
              chk("flag_restore_en_entry", 32'(flag_restore_en), 32'd0);
            end
            mchk = 1; mexp = e.mode_after;
          end
        end else begin
          chk("idle_strobes", {27'd0, flag_restore_en, clr_flag}, 32'd0);
          chk("idle_ack", 32'(irq_ack), 32'd0);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_mode", 32'(mode), 32'd1);
    chk("reset_stall", 32'(stall), 32'd0);
    chk("reset_pc_load", 32'(pc_load), 32'd0);
    chk("reset_epc", epc, 32'd0);
    chk("reset_fatal", 32'(fatal), 32'd0);
    chk("reset_pc_next", pc_next, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    step(0, 0, 1, '0, '0, 32'h40, 32'h0);                   // kernel->user via ERET
    step(0, 1, 0, '0, '0, 32'h100, 32'hA000_0000);          // SWI in user
    step(0, 0, 1, '0, '0, 32'h104, 32'h0);                  // back to user
    step(0, 0, 0, 4'b0110, 4'b0010, 32'h200, 32'h5000_0000); // IRQ line 2
    step(0, 0, 0, 4'b0110, 4'b0010, 32'h204, 32'h0);        // kernel: no entry
    step(0, 0, 1, '0, '0, 32'h208, 32'h0);                  // ERET restores 5
    step(0, 0, 1, '0, '0, 32'h300, 32'h0);                  // ERET in user -> UND
    step(1, 0, 0, '0, '0, 32'h304, 32'h0);                  // UND in kernel -> fatal
    step(0, 0, 1, '0, '0, 32'h308, 32'h0);
    step(1, 0, 0, 4'b1111, 4'b0000, 32'h400, 32'h3000_0000); // UND beats IRQ
    step(0, 0, 1, '0, '0, 32'h404, 32'h0);

    // Reset while in SAVE
    @(posedge clk); #1;
    und_req = 1'b1; irq_req = '0; pc_cur = 32'h500; status_in = 32'h1234_5678;
    pu = 1;
    @(posedge clk); #1;
    und_req = 1'b0; instr_boundary = 1'b1;
    bq.push_back('{stall: 1'b1, fatal: m_fatal});
    @(posedge clk); #1;
    instr_boundary = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    chk("midreset_epc", epc, 32'd0);
    chk("midreset_stall", 32'(stall), 32'd0);
    chk("midreset_mode", 32'(mode), 32'd1);
    chk("midreset_fatal", 32'(fatal), 32'd0);
    model_reset();
    @(posedge clk); #1;
    rst_n = 1'b1;

    for (int i = 0; i < 60; i++) begin
      step(($urandom % 8) == 0, ($urandom % 3) == 0, ($urandom % 3) == 0,
           N'($urandom), N'($urandom), $urandom & 32'hFFFF_FFFC, $urandom);
    end

    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("scoreboard_drained", 32'(q.size()), 32'd0);
    chk("boundary_q_drained", 32'(bq.size()), 32'd0);
    chk("final_fatal", 32'(fatal), 32'(m_fatal));
    chk("final_mode", 32'(mode), 32'(m_mode));
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
